// File: rtl/sprite_blit_addr_gen.sv
// Sprite blit address generator: walks a SPR_W x SPR_H sprite in ROM order and
// emits (ROM address, screen address) beats, clipping pixels that fall off-screen.
module sprite_blit_addr_gen #(
   parameter int SPR_W  = 30,
   parameter int SPR_H  = 30,
   parameter int SCR_W  = 640,
   parameter int SCR_H  = 480,
   parameter int ADDR_W = 19
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start,
   input  logic [ADDR_W-1:0] startaddr,
   input  logic [1:0]        orient,
   input  logic              ready,
   output logic              valid,
   output logic [ADDR_W-1:0] memAddr,
   output logic [ADDR_W-1:0] pixAddr,
   output logic              busy,
   output logic              done
);

   localparam int CW = $clog2(SCR_W);
   localparam int RW = $clog2(SCR_H + 1);
   localparam int XW = $clog2(SPR_W);
   localparam int YW = $clog2(SPR_H);

   localparam logic [ADDR_W-1:0] SCR_W_A   = ADDR_W'(SCR_W);
   localparam logic [ADDR_W-1:0] SPR_SZ_A  = ADDR_W'(SPR_W * SPR_H);
   localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(SCR_W - (SPR_W - 1));
   localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
   localparam logic [RW-1:0]     SCR_H_R   = RW'(SCR_H);
   localparam logic [RW-1:0]     ONE_R     = RW'(1);
   localparam logic [XW-1:0]     C_LAST    = XW'(SPR_W - 1);
   localparam logic [YW-1:0]     R_LAST    = YW'(SPR_H - 1);
   localparam logic [XW-1:0]     ONE_X     = XW'(1);
   localparam logic [YW-1:0]     ONE_Y     = YW'(1);
   localparam logic [CW:0]       SCR_W_C   = (CW + 1)'(SCR_W);
   localparam logic [RW:0]       SCR_H_RR  = (RW + 1)'(SCR_H);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_FIN} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] rem;
   logic [RW-1:0]     row0;
   logic [CW-1:0]     col0;
   logic [XW-1:0]     c;
   logic [YW-1:0]     r;
   logic [ADDR_W-1:0] mem_q, pix_q;
   logic [CW:0]       col_sum;
   logic [RW:0]       row_sum;
   logic              on_screen, advance, last_pix, row_off, rem_small;

   // Clipping test: sprite-relative counters offset by the anchor position.
   always_comb begin
      col_sum   = (CW + 1)'(col0) + (CW + 1)'(c);
      row_sum   = (RW + 1)'(row0) + (RW + 1)'(r);
      on_screen = (col_sum < SCR_W_C) && (row_sum < SCR_H_RR);
      advance   = (state == S_RUN) && (!on_screen || ready);
      last_pix  = (c == C_LAST) && (r == R_LAST);
      row_off   = (row0 >= SCR_H_R);
      rem_small = (rem < SCR_W_A);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_SETUP;
         S_SETUP: begin
            if (row_off)        state_nxt = S_FIN;
            else if (rem_small) state_nxt = S_RUN;
         end
         S_RUN:   if (advance && last_pix) state_nxt = S_FIN;
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      valid = (state == S_RUN) && on_screen;
      busy  = (state != S_IDLE);
      done  = (state == S_FIN);
   end

   assign memAddr = mem_q;
   assign pixAddr = pix_q;

   // Division-free row/col split: repeated subtraction, one row per cycle.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rem   <= '0;
         row0  <= '0;
         col0  <= '0;
         c     <= '0;
         r     <= '0;
         mem_q <= '0;
         pix_q <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               rem   <= startaddr;
               row0  <= '0;
               c     <= '0;
               r     <= '0;
               pix_q <= startaddr;
               // constant multiply by the sprite size reduces to shift/add
               mem_q <= ADDR_W'(orient) * SPR_SZ_A;
            end
            S_SETUP: begin
               if (!row_off && !rem_small) begin
                  rem  <= rem - SCR_W_A;
                  row0 <= row0 + ONE_R;
               end else begin
                  col0 <= rem[CW-1:0];
               end
            end
            S_RUN: if (advance) begin
               mem_q <= mem_q + ONE_A;
               if (c == C_LAST) begin
                  c     <= '0;
                  r     <= r + ONE_Y;
                  pix_q <= pix_q + ROW_STEP;
               end else begin
                  c     <= c + ONE_X;
                  pix_q <= pix_q + ONE_A;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_blit_addr_gen.sv
// Randomized bench for sprite_blit_addr_gen against a per-pixel reference list.
module tb_sprite_blit_addr_gen;

   logic        clock = 0;
   logic        resetn;
   logic        start;
   logic [18:0] startaddr;
   logic [1:0]  orient;
   logic        ready;
   logic        valid, busy, done;
   logic [18:0] memAddr, pixAddr;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [37:0] exp_q[$];

   sprite_blit_addr_gen dut (
      .clock(clock), .resetn(resetn), .start(start), .startaddr(startaddr),
      .orient(orient), .ready(ready), .valid(valid), .memAddr(memAddr),
      .pixAddr(pixAddr), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   // Expected beat list: every sprite pixel whose screen row/col is in range.
   task automatic build_model(input int sa, input int o);
      int row0, col0;
      exp_q.delete();
      if (sa >= 640 * 480) return;
      row0 = sa / 640;
      col0 = sa % 640;
      for (int y = 0; y < 30; y++)
         for (int x = 0; x < 30; x++)
            if (col0 + x < 640 && row0 + y < 480)
               exp_q.push_back({19'(900 * o + 30 * y + x), 19'(sa + 640 * y + x)});
   endtask

   task automatic run_walk(input int sa, input int o, input int mode, input bit poke);
      bit   got_done = 0;
      int   first_lat = -1;
      bit   pv = 0, pr = 0;
      int   pm = 0, pp = 0;
      int   nbeats;
      logic [37:0] e;
      build_model(sa, o);
      nbeats = exp_q.size();
      @(negedge clock);
      start = 1; startaddr = 19'(sa); orient = 2'(o); ready = 0;
      for (int it = 1; it <= 4000 && !got_done; it++) begin
         @(negedge clock);
         start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
         if (poke) begin
            startaddr = 19'($urandom_range(0, 307199));
            orient    = 2'($urandom_range(0, 3));
         end
         case (mode)
            0:       ready = 1;
            1:       ready = ((cyc / 3) % 2) == 0;
            default: ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (pv && !pr) begin
            chk("hold_valid", valid, 1);
            chk("hold_mem", memAddr, pm);
            chk("hold_pix", pixAddr, pp);
         end
         if (valid) begin
            if (first_lat < 0) first_lat = it;
            if (ready) begin
               if (exp_q.size() == 0) chk("extra_beat", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("beat_mem", memAddr, e[37:19]);
                  chk("beat_pix", pixAddr, e[18:0]);
               end
            end
         end
         if (done) begin
            got_done = 1;
            chk("done_valid", valid, 0);
            chk("done_busy", busy, 1);
         end
         pv = valid; pr = ready; pm = memAddr; pp = pixAddr;
      end
      start = 0;
      chk("walk_done_seen", got_done, 1);
      chk("beats_left", exp_q.size(), 0);
      if (nbeats > 0) chk("first_latency", first_lat, sa / 640 + 2);
      else            chk("no_beats", first_lat, -1);
      @(negedge clock);
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
   endtask

   initial begin
      resetn = 0; start = 0; startaddr = 0; orient = 0; ready = 0;
      #3;
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mem", memAddr, 0);
      chk("rst_pix", pixAddr, 0);
      @(negedge clock);
      resetn = 1;

      run_walk(0, 0, 0, 0);
      run_walk(6405, 3, 0, 0);
      run_walk(620, 1, 0, 0);
      run_walk(300800, 0, 0, 0);
      run_walk(307200, 2, 0, 0);
      run_walk(524287, 1, 0, 0);
      run_walk(0, 0, 1, 0);
      run_walk(307199, 2, 2, 1);

      // reset in the middle of a walk, then a fresh walk
      @(negedge clock);
      start = 1; startaddr = 19'd1000; orient = 2'd2; ready = 1;
      @(negedge clock);
      start = 0;
      repeat (60) @(negedge clock);
      resetn = 0;
      #1;
      chk("midrst_valid", valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_mem", memAddr, 0);
      chk("midrst_pix", pixAddr, 0);
      @(negedge clock);
      resetn = 1;
      run_walk(12345, 1, 2, 0);

      for (int k = 0; k < 10; k++) begin
         int sa;
         case ($urandom_range(0, 3))
            0:       sa = 640 * $urandom_range(0, 479) + $urandom_range(600, 639);
            1:       sa = 640 * $urandom_range(440, 479) + $urandom_range(0, 639);
            default: sa = $urandom_range(0, 307199);
         endcase
         run_walk(sa, $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
